// File: rtl/congestion_estimator.sv
// Congestion estimator: synchronises and debounces the NS/EW loop detectors, counts arrivals
// per window, and quantises the lane sum to a 2-bit level. Optional CONG_HYST_EN adds down-hysteresis.

module congestion_lane #(
   parameter int DEBOUNCE    = 4,
   parameter int CNT_W       = 12,
   parameter int STUCK_TICKS = 500
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             det_i,
   input  logic             close_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             fault_o,
   output logic             fault_nxt_o
);
   localparam int RUN_W = $clog2(DEBOUNCE + 1);
   localparam int TMR_W = $clog2(STUCK_TICKS + 1);

   logic             s1_q, s2_q;
   logic             filt_q, filt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             fault_q, fault_d;
   logic             arr;

   always_comb begin
      run_d  = '0;
      filt_d = filt_q;
      arr    = 1'b0;
      if (s2_q != filt_q) begin
         if (run_q == RUN_W'(DEBOUNCE - 1)) begin
            filt_d = s2_q;
            arr    = s2_q;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
      // count includes an arrival landing on the close cycle; saturates, never wraps
      cnt_inc = (arr && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
      cnt_d   = close_i ? '0 : cnt_inc;
      if (!filt_q)
         tmr_d = '0;
      else if (tmr_q == TMR_W'(STUCK_TICKS))
         tmr_d = tmr_q;
      else
         tmr_d = tmr_q + 1'b1;
      fault_d = fault_q | (tmr_d == TMR_W'(STUCK_TICKS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         filt_q  <= 1'b0;
         run_q   <= '0;
         cnt_q   <= '0;
         tmr_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         s1_q    <= det_i;
         s2_q    <= s1_q;
         filt_q  <= filt_d;
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         tmr_q   <= tmr_d;
         fault_q <= fault_d;
      end
   end

   assign cnt_o       = cnt_inc;
   assign fault_o     = fault_q;
   assign fault_nxt_o = fault_d;
endmodule

module congestion_estimator #(
   parameter int WINDOW_TICKS = 1000,
   parameter int DEBOUNCE     = 4,
   parameter int TH1          = 5,
   parameter int TH2          = 12,
   parameter int TH3          = 20,
   parameter int CNT_W        = 12,
   parameter int STUCK_TICKS  = 500,
   parameter int HYST         = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           det_ns,
   input  logic           det_ew,
   output logic [1:0]     congestion_level,
   output logic           level_valid,
   output logic [CNT_W:0] veh_count_total,
   output logic [1:0]     det_fault
);
   localparam int NUM_LANES = 2;
   localparam int WCNT_W    = $clog2(WINDOW_TICKS);

   logic [NUM_LANES-1:0]            det_raw;
   logic [NUM_LANES-1:0][CNT_W-1:0] lane_cnt;
   logic [NUM_LANES-1:0]            lane_flt, lane_flt_nxt;
   logic [WCNT_W-1:0]               wcnt_q, wcnt_d;
   logic                            close;
   logic [CNT_W:0]                  sum;
   logic [CNT_W:0]                  tot_q, tot_d;
   logic [1:0]                      lvl_q, lvl_d, q;
   logic                            vld_q, vld_d;

   assign det_raw = {det_ew, det_ns};
   assign close   = (wcnt_q == WCNT_W'(WINDOW_TICKS - 1));

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      congestion_lane #(
         .DEBOUNCE   (DEBOUNCE),
         .CNT_W      (CNT_W),
         .STUCK_TICKS(STUCK_TICKS)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .det_i      (det_raw[l]),
         .close_i    (close),
         .cnt_o      (lane_cnt[l]),
         .fault_o    (lane_flt[l]),
         .fault_nxt_o(lane_flt_nxt[l])
      );
   end

   function automatic logic [1:0] quant(input logic [CNT_W:0] s);
      if (int'(s) >= TH3)      return 2'd3;
      else if (int'(s) >= TH2) return 2'd2;
      else if (int'(s) >= TH1) return 2'd1;
      else                     return 2'd0;
   endfunction

`ifdef CONG_HYST_EN
   function automatic int th_of(input logic [1:0] lv);
      case (lv)
         2'd1:    return TH1;
         2'd2:    return TH2;
         default: return TH3;
      endcase
   endfunction
`endif

   // a lane whose fault sets during this window (even on the close cycle) contributes nothing
   always_comb begin
      sum = '0;
      for (int l = 0; l < NUM_LANES; l++)
         if (!lane_flt_nxt[l]) sum = sum + {1'b0, lane_cnt[l]};
   end

   always_comb begin
      wcnt_d = close ? '0 : wcnt_q + 1'b1;
      tot_d  = tot_q;
      lvl_d  = lvl_q;
      vld_d  = 1'b0;
      q      = quant(sum);
      if (close) begin
         vld_d = 1'b1;
         tot_d = sum;
         if (&lane_flt_nxt)
            lvl_d = 2'd3;
`ifdef CONG_HYST_EN
         else if ((q >= lvl_q) || (int'(sum) < th_of(lvl_q) - HYST))
            lvl_d = q;
`else
         else
            lvl_d = q;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         tot_q  <= '0;
         lvl_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         tot_q  <= tot_d;
         lvl_q  <= lvl_d;
         vld_q  <= vld_d;
      end
   end

   assign congestion_level = lvl_q;
   assign level_valid      = vld_q;
   assign veh_count_total  = tot_q;
   assign det_fault        = lane_flt;
endmodule

// File: tb/tb_congestion_estimator.sv
// Randomised bench for congestion_estimator: behavioural model feeds a scoreboard,
// an independent monitor checks every level_valid pulse and the held level.

module tb_congestion_estimator;
   localparam int W    = 100;
   localparam int D    = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int ST   = 50;
   localparam int T1   = 5;
   localparam int T2   = 12;
   localparam int T3   = 20;
   localparam int HY   = 2;

   localparam int M_IDLE = 0, M_GLITCH = 1, M_DENSE = 2, M_NORMAL = 3, M_SPARSE = 4, M_STUCK = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          det_ns = 1'b0, det_ew = 1'b0;
   logic [1:0]    congestion_level;
   logic          level_valid;
   logic [CW:0]   veh_count_total;
   logic [1:0]    det_fault;

   congestion_estimator #(
      .WINDOW_TICKS(W), .DEBOUNCE(D), .TH1(T1), .TH2(T2), .TH3(T3),
      .CNT_W(CW), .STUCK_TICKS(ST), .HYST(HY)
   ) dut (
      .clk(clk), .rst(rst), .det_ns(det_ns), .det_ew(det_ew),
      .congestion_level(congestion_level), .level_valid(level_valid),
      .veh_count_total(veh_count_total), .det_fault(det_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [CW:0] tot;
      logic [1:0]  lvl;
      logic [1:0]  flt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0, errors = 0;
   bit   started = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---- reference model: history bit-vectors, plain counts ----
   int rawh[2], synh[2], filt[2], hi[2], flt[2], cnt[2];
   int wc, mlvl;

   function automatic int quant(input int s);
      return (s >= T3) ? 3 : (s >= T2) ? 2 : (s >= T1) ? 1 : 0;
   endfunction

   function automatic int th_of(input int lv);
      return (lv == 1) ? T1 : (lv == 2) ? T2 : T3;
   endfunction

   task automatic model_step();
      int mask, sum, so, raw, c, ql, nl;
      bit cl;
      mask = (1 << D) - 1;
      if (rst) begin
         for (int l = 0; l < 2; l++) begin
            rawh[l] = 0; synh[l] = 0; filt[l] = 0; hi[l] = 0; flt[l] = 0; cnt[l] = 0;
         end
         wc = 0; mlvl = 0;
         return;
      end
      cl  = (wc == W - 1);
      sum = 0;
      for (int l = 0; l < 2; l++) begin
         raw     = (l == 0) ? int'(det_ns) : int'(det_ew);
         so      = (rawh[l] >> 1) & 1;          // synchroniser output = input two edges ago
         rawh[l] = ((rawh[l] << 1) | raw) & 3;
         synh[l] = ((synh[l] << 1) | so) & mask;
         hi[l]   = filt[l] ? hi[l] + 1 : 0;
         if (hi[l] >= ST) flt[l] = 1;
         c = cnt[l];
         if (synh[l] == (filt[l] ? 0 : mask)) begin
            filt[l] = 1 - filt[l];
            if (filt[l] == 1) c = (c + 1 > CMAX) ? CMAX : c + 1;
         end
         if (flt[l] == 0) sum += c;
         cnt[l] = cl ? 0 : c;
      end
      wc = cl ? 0 : wc + 1;
      if (cl) begin
         ql = quant(sum);
         if (flt[0] == 1 && flt[1] == 1) nl = 3;
`ifdef CONG_HYST_EN
         else if (ql >= mlvl || sum < th_of(mlvl) - HY) nl = ql;
         else nl = mlvl;
`else
         else nl = ql;
`endif
         mlvl = nl;
         exp_q.push_back('{tot: (CW+1)'(sum), lvl: 2'(nl), flt: {1'(flt[1]), 1'(flt[0])}});
      end
   endtask

   // ---- stimulus generator ----
   int glvl[2], grem[2], gmode[2];

   function automatic int hold(input int mode, input int lv);
      case (mode)
         M_GLITCH: return lv ? 1 : int'($urandom_range(3, 8));
         M_DENSE:  return int'($urandom_range(2, 3));
         M_NORMAL: return int'($urandom_range(2, 10));
         M_SPARSE: return int'($urandom_range(4, 20));
         M_STUCK:  return lv ? int'($urandom_range(55, 90)) : int'($urandom_range(2, 8));
         default:  return 1000;
      endcase
   endfunction

   task automatic set_modes(input int m0, input int m1);
      gmode[0] = m0; gmode[1] = m1; grem[0] = 0; grem[1] = 0;
   endtask

   task automatic step(input bit r);
      @(negedge clk);
      rst = r;
      for (int l = 0; l < 2; l++) begin
         if (gmode[l] == M_IDLE) glvl[l] = 0;
         else begin
            if (grem[l] <= 0) begin
               glvl[l] = 1 - glvl[l];
               grem[l] = hold(gmode[l], glvl[l]);
            end
            grem[l]--;
         end
      end
      det_ns = glvl[0][0];
      det_ew = glvl[1][0];
      @(posedge clk);
      model_step();
   endtask

   task automatic reset_pulse();
      step(1'b1);
      #1;
      chk("rst_level", int'(congestion_level), 0);
      chk("rst_valid", int'(level_valid), 0);
      chk("rst_total", int'(veh_count_total), 0);
      chk("rst_fault", int'(det_fault), 0);
      started = 1;
   endtask

   task automatic run_windows(input int n, input bit rand_modes, input int rst_at);
      for (int w = 0; w < n; w++) begin
         if (rand_modes)
            set_modes(int'($urandom_range(M_IDLE, M_SPARSE)), int'($urandom_range(M_IDLE, M_SPARSE)));
         for (int i = 0; i < W; i++) begin
            if (w == 0 && i == rst_at) reset_pulse();
            else step(1'b0);
         end
      end
   endtask

   // ---- monitor ----
   always @(negedge clk) begin
      if (started && !rst) begin
         if (level_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("total", int'(veh_count_total), int'(e.tot));
               chk("level", int'(congestion_level), int'(e.lvl));
               chk("fault", int'(det_fault), int'(e.flt));
            end
         end else if (exp_q.size() != 0) begin
            chk("missed_valid", int'(exp_q.size()), 0);
            exp_q.delete();
         end else begin
            chk("level_hold", int'(congestion_level), mlvl);
         end
      end
   end

   initial begin
      set_modes(M_IDLE, M_IDLE);
      reset_pulse();
      // first pulse must come exactly W cycles after release
      for (int i = 0; i < W - 1; i++) step(1'b0);
      #1 chk("first_valid_early", int'(level_valid), 0);
      step(1'b0);
      #1 chk("first_valid", int'(level_valid), 1);
      set_modes(M_DENSE, M_DENSE);
      run_windows(3, 1'b0, -1);                 // saturating counts
      set_modes(M_GLITCH, M_GLITCH);
      run_windows(2, 1'b0, -1);                 // glitches filtered out
      run_windows(10, 1'b1, -1);                // random mixes across all levels
      set_modes(M_NORMAL, M_DENSE);
      run_windows(2, 1'b0, int'($urandom_range(10, 90)));  // mid-window reset
      set_modes(M_STUCK, M_NORMAL);
      run_windows(4, 1'b0, -1);
      set_modes(M_STUCK, M_STUCK);
      run_windows(5, 1'b0, -1);
      set_modes(M_IDLE, M_NORMAL);
      run_windows(2, 1'b0, -1);                 // fault stays sticky after release
      reset_pulse();
      set_modes(M_NORMAL, M_SPARSE);
      run_windows(3, 1'b0, -1);
      step(1'b0);
      step(1'b0);
      chk("queue_drained", int'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
